// File: rtl/tipi_chan_bridge.sv
// TIPI channel bridge: NCH byte registers each way between the TI memory window
// and an oversampled RPi serial link, with pending flags raising attention lines.

module tipi_chan_reg #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          t_wr,
   input  logic          t_clr,
   input  logic          r_wr,
   input  logic          r_clr,
   input  logic [0:DW-1] t_wdata,
   input  logic [0:DW-1] r_wdata,
   output logic [0:DW-1] t_q,
   output logic [0:DW-1] r_q,
   output logic          t_pend,
   output logic          r_pend
);

   // Set is evaluated after clear so a same-cycle set/clear leaves the flag set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         t_q    <= '0;
         r_q    <= '0;
         t_pend <= 1'b0;
         r_pend <= 1'b0;
      end else begin
         if (t_wr) t_q <= t_wdata;
         if (r_wr) r_q <= r_wdata;
         if (t_clr) t_pend <= 1'b0;
         if (t_wr)  t_pend <= 1'b1;
         if (r_clr) r_pend <= 1'b0;
         if (r_wr)  r_pend <= 1'b1;
      end
   end

endmodule

module tipi_chan_bridge #(
   parameter int          NCH         = 2,
   parameter int          DW          = 8,
   parameter logic [15:0] BASE_ADDR   = 16'h5FF8,
   parameter int          SYNC_STAGES = 2,
   parameter int          SW          = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          dev_en,
   input  logic [0:15]   ti_a,
   input  logic          ti_memen,
   input  logic          ti_we,
   input  logic          ti_dbin,
   input  logic [0:DW-1] ti_din,
   output logic [0:DW-1] ti_dout,
   output logic          ti_dout_en,
   output logic          ti_attn,
   input  logic          r_clk,
   input  logic          r_le,
   input  logic          r_rt,
   input  logic          r_dout,
   input  logic [SW-1:0] r_sel,
   output logic          r_din,
   output logic          rpi_attn
);

   typedef struct packed {
      logic          rd;
      logic          wr;
      logic [SW-1:0] sel;
      logic          dout;
      logic          rt;
      logic          le;
      logic          rclk;
   } async_t;

   logic [NCH-1:0]         hit_r, hit_t, sel_hot, rd_hot;
   logic [NCH-1:0]         t_wr, t_clr, r_wr, r_clr, r_pend, t_pend;
   logic [NCH-1:0][0:DW-1] r_q, t_q;
   logic [0:DW-1]          t_sel, in_sh, out_sh;

   async_t                        raw, s;
   async_t [SYNC_STAGES-1:0]      sync_q;
   logic                          rclk_d, wr_d, rd_d;
   logic                          rclk_rise, wr_rise, rd_rise, rd_fall;

   // Address decode is a per-channel equality against the odd window addresses.
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      localparam logic [15:0] R_ADDR = 16'(BASE_ADDR + 2*c + 1);
      localparam logic [15:0] T_ADDR = 16'(BASE_ADDR + 2*NCH + 2*c + 1);

      assign hit_r[c]   = (ti_a == R_ADDR);
      assign hit_t[c]   = (ti_a == T_ADDR);
      assign sel_hot[c] = (s.sel == SW'(c));

      tipi_chan_reg #(.DW(DW)) u_reg (
         .clk     (clk),
         .reset_n (reset_n),
         .t_wr    (t_wr[c]),
         .t_clr   (t_clr[c]),
         .r_wr    (r_wr[c]),
         .r_clr   (r_clr[c]),
         .t_wdata (ti_din),
         .r_wdata (in_sh),
         .t_q     (t_q[c]),
         .r_q     (r_q[c]),
         .t_pend  (t_pend[c]),
         .r_pend  (r_pend[c])
      );
   end

   assign ti_dout_en = dev_en & ~ti_memen & ti_dbin & (|hit_r | |hit_t);

   always_comb begin
      ti_dout = '0;
      t_sel   = '0;
      for (int c = 0; c < NCH; c++) begin
         if (hit_r[c])   ti_dout = ti_dout | r_q[c];
         if (hit_t[c])   ti_dout = ti_dout | t_q[c];
         if (sel_hot[c]) t_sel   = t_sel | t_q[c];
      end
   end

   assign raw.rd   = dev_en & ~ti_memen & ti_dbin & (|hit_r);
   assign raw.wr   = dev_en & ~ti_memen & ~ti_we & (|hit_t);
   assign raw.sel  = r_sel;
   assign raw.dout = r_dout;
   assign raw.rt   = r_rt;
   assign raw.le   = r_le;
   assign raw.rclk = r_clk;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         rclk_d <= 1'b0;
         wr_d   <= 1'b0;
         rd_d   <= 1'b0;
      end else begin
         sync_q[0] <= raw;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         rclk_d <= s.rclk;
         wr_d   <= s.wr;
         rd_d   <= s.rd;
      end
   end

   assign s         = sync_q[SYNC_STAGES-1];
   assign rclk_rise = s.rclk & ~rclk_d;
   assign wr_rise   = s.wr & ~wr_d;
   assign rd_rise   = s.rd & ~rd_d;
   assign rd_fall   = ~s.rd & rd_d;

   // The TI bus is still held when the synced strobe edge arrives, so raw
   // address/data are safe to use here; the read target is latched at its start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     rd_hot <= '0;
      else if (rd_rise) rd_hot <= hit_r;
   end

   assign t_wr  = {NCH{wr_rise}} & hit_t;
   assign r_clr = {NCH{rd_fall}} & rd_hot;
   assign t_clr = {NCH{rclk_rise & s.le & s.rt}} & sel_hot;
   assign r_wr  = {NCH{rclk_rise & s.le & ~s.rt}} & sel_hot;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         in_sh  <= '0;
         out_sh <= '0;
         r_din  <= 1'b0;
      end else begin
         r_din <= out_sh[0];
         if (rclk_rise) begin
            case ({s.le, s.rt})
               2'b11:   out_sh <= t_sel;
               2'b01:   out_sh <= {out_sh[1:DW-1], 1'b0};
               2'b00:   in_sh  <= {in_sh[1:DW-1], s.dout};
               default: ;
            endcase
         end
      end
   end

   assign ti_attn  = |r_pend;
   assign rpi_attn = |t_pend;

endmodule

// File: tb/tb_tipi_chan_bridge.sv
// Randomised bench for tipi_chan_bridge: an NCH=2 and an NCH=4 instance share the
// stimulus and are checked against a transaction-level model of both.

module tb_tipi_chan_bridge;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       dev_en, ti_memen, ti_we, ti_dbin;
   logic [0:15] ti_a;
   logic [0:7] ti_din;
   logic       r_clk, r_le, r_rt, r_dout;
   logic [1:0] r_sel;
   logic [0:7] dout2, dout4;
   logic       en2, en4, tattn2, tattn4, din2, din4, rattn2, rattn4;

   always #5 clk = ~clk;

   tipi_chan_bridge #(.NCH(2), .DW(8), .BASE_ADDR(16'h5FF8), .SYNC_STAGES(2)) u2 (
      .clk(clk), .reset_n(reset_n), .dev_en(dev_en), .ti_a(ti_a), .ti_memen(ti_memen),
      .ti_we(ti_we), .ti_dbin(ti_dbin), .ti_din(ti_din), .ti_dout(dout2), .ti_dout_en(en2),
      .ti_attn(tattn2), .r_clk(r_clk), .r_le(r_le), .r_rt(r_rt), .r_dout(r_dout),
      .r_sel(r_sel[0:0]), .r_din(din2), .rpi_attn(rattn2));

   tipi_chan_bridge #(.NCH(4), .DW(8), .BASE_ADDR(16'h5FF0), .SYNC_STAGES(2)) u4 (
      .clk(clk), .reset_n(reset_n), .dev_en(dev_en), .ti_a(ti_a), .ti_memen(ti_memen),
      .ti_we(ti_we), .ti_dbin(ti_dbin), .ti_din(ti_din), .ti_dout(dout4), .ti_dout_en(en4),
      .ti_attn(tattn4), .r_clk(r_clk), .r_le(r_le), .r_rt(r_rt), .r_dout(r_dout),
      .r_sel(r_sel), .r_din(din4), .rpi_attn(rattn4));

   int chk_cnt = 0;
   int pass_cnt = 0;

   // Model state, index [dut][channel]; dut 0 = NCH 2, dut 1 = NCH 4.
   int mR [2][4];
   int mT [2][4];
   bit mRp[2][4];
   bit mTp[2][4];
   int mIn [2];
   int mOut[2];

   logic [7:0] obs_dout[2];
   logic       obs_en[2];
   logic       obs_din[2];

   function automatic int nch_of(int d);  return d ? 4 : 2; endfunction
   function automatic int base_of(int d); return d ? 'h5FF0 : 'h5FF8; endfunction

   // -1 = no hit, 0..15 = R channel, 16.. = T channel
   function automatic int dec(int d, int a);
      int off;
      off = a - base_of(d);
      if (off < 0 || off >= 4 * nch_of(d) || (off % 2) == 0) return -1;
      if (off / 2 < nch_of(d)) return off / 2;
      return 16 + off / 2 - nch_of(d);
   endfunction

   function automatic int mval(int d, int a);
      int k;
      k = dec(d, a);
      if (k < 0) return 0;
      if (k < 16) return mR[d][k];
      return mT[d][k-16];
   endfunction

   function automatic bit m_tattn(int d);
      bit r = 0;
      for (int c = 0; c < 4; c++) r |= mRp[d][c];
      return r;
   endfunction

   function automatic bit m_rattn(int d);
      bit r = 0;
      for (int c = 0; c < 4; c++) r |= mTp[d][c];
      return r;
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 4; c++) begin
            mR[d][c] = 0; mT[d][c] = 0; mRp[d][c] = 0; mTp[d][c] = 0;
         end
         mIn[d] = 0; mOut[d] = 0;
      end
   endfunction

   function automatic void model_rpi(bit le, bit rt, int sel, bit dout);
      for (int d = 0; d < 2; d++) begin
         int sc;
         sc = sel % nch_of(d);
         if (le && rt) begin
            mOut[d] = mT[d][sc]; mTp[d][sc] = 0;
         end else if (le) begin
            mR[d][sc] = mIn[d]; mRp[d][sc] = 1;
         end else if (rt) mOut[d] = (mOut[d] << 1) & 'hFF;
         else mIn[d] = ((mIn[d] << 1) | int'(dout)) & 'hFF;
      end
   endfunction

   function automatic void model_write(int a, int v);
      for (int d = 0; d < 2; d++) begin
         int k;
         k = dec(d, a);
         if (k >= 16) begin
            mT[d][k-16] = v; mTp[d][k-16] = 1;
         end
      end
   endfunction

   task automatic idle_bus();
      dev_en = 1'b1; ti_memen = 1'b1; ti_we = 1'b1; ti_dbin = 1'b0;
   endtask

   task automatic ti_write(input int a, input int v);
      @(negedge clk);
      ti_a = 16'(a); ti_din = 8'(v); dev_en = 1'b1; ti_memen = 1'b0; ti_we = 1'b0;
      repeat (8) @(negedge clk);
      idle_bus();
      model_write(a, v);
      repeat (6) @(negedge clk);
   endtask

   task automatic ti_read(input int a);
      @(negedge clk);
      ti_a = 16'(a); dev_en = 1'b1; ti_memen = 1'b0; ti_dbin = 1'b1;
      repeat (8) @(negedge clk);
      obs_dout[0] = dout2; obs_en[0] = en2;
      obs_dout[1] = dout4; obs_en[1] = en4;
      idle_bus();
      for (int d = 0; d < 2; d++) begin
         int k;
         k = dec(d, a);
         if (k >= 0 && k < 16) mRp[d][k] = 0;
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic rpi_ev(input bit le, input bit rt, input int sel, input bit dout);
      r_le = le; r_rt = rt; r_sel = 2'(sel); r_dout = dout;
      repeat (6) @(negedge clk);
      r_clk = 1'b1;
      model_rpi(le, rt, sel, dout);
      repeat (6) @(negedge clk);
      obs_din[0] = din2; obs_din[1] = din4;
      r_clk = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({din2, tattn2, rattn2, en2, dout2} !== 12'h000)
         $display("FAIL reset_out_n2: got din/tattn/rattn/en/dout=%b%b%b%b/%h want all 0", din2, tattn2, rattn2, en2, dout2);
      else pass_cnt++;
      chk_cnt++;
      if ({din4, tattn4, rattn4, en4, dout4} !== 12'h000)
         $display("FAIL reset_out_n4: got din/tattn/rattn/en/dout=%b%b%b%b/%h want all 0", din4, tattn4, rattn4, en4, dout4);
      else pass_cnt++;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_window();
      for (int a = 'h5FEE; a <= 'h6001; a++) begin
         ti_read(a);
         for (int d = 0; d < 2; d++) begin
            chk_cnt++;
            if (obs_en[d] !== (dec(d, a) >= 0))
               $display("FAIL window_en d%0d a=%h: got %b want %b", d, a, obs_en[d], dec(d, a) >= 0);
            else pass_cnt++;
            chk_cnt++;
            if (obs_dout[d] !== 8'(mval(d, a)))
               $display("FAIL window_dout d%0d a=%h: got %h want %h", d, a, obs_dout[d], 8'(mval(d, a)));
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_ti_write();
      logic [7:0] seq;
      ti_write('h5FFF, 'hA5);
      chk_cnt++;
      if ({rattn2, rattn4} !== {m_rattn(0), m_rattn(1)})
         $display("FAIL wr_rpi_attn: got %b%b want %b%b", rattn2, rattn4, m_rattn(0), m_rattn(1));
      else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         rpi_ev(i == 0, 1'b1, 1, 1'b0);
         seq[7-i] = obs_din[0];
         for (int d = 0; d < 2; d++) begin
            chk_cnt++;
            if (obs_din[d] !== mOut[d][7])
               $display("FAIL shift_out d%0d bit%0d: got %b want %b", d, i, obs_din[d], mOut[d][7]);
            else pass_cnt++;
         end
         if (i == 0) begin
            chk_cnt++;
            if ({rattn2, rattn4} !== {m_rattn(0), m_rattn(1)})
               $display("FAIL load_rpi_attn: got %b%b want %b%b", rattn2, rattn4, m_rattn(0), m_rattn(1));
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if (seq !== 8'hA5) $display("FAIL a5_sequence: got %h want a5", seq);
      else pass_cnt++;
   endtask

   task automatic test_rpi_commit();
      logic [7:0] v = 8'h3C;
      for (int i = 7; i >= 0; i--) rpi_ev(1'b0, 1'b0, 0, v[i]);
      rpi_ev(1'b1, 1'b0, 0, 1'b0);
      chk_cnt++;
      if ({tattn2, tattn4} !== {m_tattn(0), m_tattn(1)})
         $display("FAIL commit_ti_attn: got %b%b want %b%b", tattn2, tattn4, m_tattn(0), m_tattn(1));
      else pass_cnt++;
      ti_read('h5FF9);
      chk_cnt++;
      if (obs_dout[0] !== 8'h3C || obs_en[0] !== 1'b1)
         $display("FAIL commit_read_n2: got %h en %b want 3c en 1", obs_dout[0], obs_en[0]);
      else pass_cnt++;
      chk_cnt++;
      if (obs_dout[1] !== 8'(mval(1, 'h5FF9)))
         $display("FAIL commit_read_n4: got %h want %h", obs_dout[1], 8'(mval(1, 'h5FF9)));
      else pass_cnt++;
      chk_cnt++;
      if ({tattn2, tattn4} !== {m_tattn(0), m_tattn(1)})
         $display("FAIL readclr_ti_attn: got %b%b want %b%b", tattn2, tattn4, m_tattn(0), m_tattn(1));
      else pass_cnt++;
   endtask

   task automatic test_simul();
      logic [7:0] oldv, newv, seq;
      oldv = 8'($urandom_range(1, 254));
      newv = ~oldv;
      ti_write('h5FFD, oldv);
      r_le = 1'b1; r_rt = 1'b1; r_sel = 2'd0; r_dout = 1'b0;
      repeat (6) @(negedge clk);
      ti_a = 16'h5FFD; ti_din = newv; dev_en = 1'b1; ti_memen = 1'b0; ti_we = 1'b0;
      r_clk = 1'b1;
      model_rpi(1'b1, 1'b1, 0, 1'b0);
      model_write('h5FFD, newv);
      repeat (8) @(negedge clk);
      idle_bus();
      seq[7] = din2;
      r_clk = 1'b0;
      repeat (6) @(negedge clk);
      chk_cnt++;
      if (din4 !== mOut[1][7]) $display("FAIL simul_load_n4: got %b want %b", din4, mOut[1][7]);
      else pass_cnt++;
      for (int i = 6; i >= 0; i--) begin
         rpi_ev(1'b0, 1'b1, 0, 1'b0);
         seq[i] = obs_din[0];
      end
      chk_cnt++;
      if (seq !== oldv) $display("FAIL simul_old_value: got %h want %h", seq, oldv);
      else pass_cnt++;
      chk_cnt++;
      if (rattn2 !== 1'b1) $display("FAIL simul_rpi_attn: got %b want 1", rattn2);
      else pass_cnt++;
      ti_read('h5FFD);
      chk_cnt++;
      if (obs_dout[0] !== newv) $display("FAIL simul_new_value: got %h want %h", obs_dout[0], newv);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] v = 8'h81;
      for (int i = 0; i < 4; i++) rpi_ev(1'b0, 1'b0, 0, 1'($urandom_range(0, 1)));
      @(negedge clk);
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_cnt++;
      if ({din2, tattn2, rattn2, dout2, din4, tattn4, rattn4, dout4} !== 22'h0)
         $display("FAIL midreset_out: got %b%b%b/%h %b%b%b/%h want all 0",
                  din2, tattn2, rattn2, dout2, din4, tattn4, rattn4, dout4);
      else pass_cnt++;
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      for (int i = 7; i >= 0; i--) rpi_ev(1'b0, 1'b0, 0, v[i]);
      rpi_ev(1'b1, 1'b0, 0, 1'b0);
      ti_read('h5FF9);
      chk_cnt++;
      if (obs_dout[0] !== 8'h81) $display("FAIL midreset_r0: got %h want 81", obs_dout[0]);
      else pass_cnt++;
   endtask

   task automatic test_nch4();
      logic [7:0] tv, rv;
      tv = 8'($urandom);
      rv = 8'($urandom);
      ti_write('h5FFF, tv);
      ti_read('h5FFF);
      chk_cnt++;
      if (obs_dout[1] !== tv || obs_dout[0] !== tv)
         $display("FAIL n4_t3: got %h/%h want %h/%h", obs_dout[1], obs_dout[0], tv, tv);
      else pass_cnt++;
      for (int i = 7; i >= 0; i--) rpi_ev(1'b0, 1'b0, 3, rv[i]);
      rpi_ev(1'b1, 1'b0, 3, 1'b0);
      ti_read('h5FF7);
      chk_cnt++;
      if (obs_dout[1] !== rv || obs_en[1] !== 1'b1)
         $display("FAIL n4_r3: got %h en %b want %h en 1", obs_dout[1], obs_en[1], rv);
      else pass_cnt++;
      chk_cnt++;
      if (obs_dout[0] !== 8'h00 || obs_en[0] !== 1'b0)
         $display("FAIL n2_outside: got %h en %b want 00 en 0", obs_dout[0], obs_en[0]);
      else pass_cnt++;
      ti_write('h5FFE, $urandom_range(0, 255));
      ti_write('h5FEF, $urandom_range(0, 255));
      ti_write('h6001, $urandom_range(0, 255));
      ti_write('h5FF2, $urandom_range(0, 255));
      for (int a = 'h5FF1; a <= 'h5FFF; a += 2) begin
         ti_read(a);
         for (int d = 0; d < 2; d++) begin
            chk_cnt++;
            if (obs_dout[d] !== 8'(mval(d, a)))
               $display("FAIL nohit_write d%0d a=%h: got %h want %h", d, a, obs_dout[d], 8'(mval(d, a)));
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         int op, a, sel;
         op  = $urandom_range(0, 3);
         a   = 'h5FEE + $urandom_range(0, 19);
         sel = $urandom_range(0, 3);
         case (op)
            0: ti_write(a, $urandom_range(0, 255));
            1: begin
               ti_read(a);
               for (int d = 0; d < 2; d++) begin
                  chk_cnt++;
                  if (obs_dout[d] !== 8'(mval(d, a)) || obs_en[d] !== (dec(d, a) >= 0))
                     $display("FAIL rand_read d%0d a=%h: got %h/%b want %h/%b", d, a,
                              obs_dout[d], obs_en[d], 8'(mval(d, a)), dec(d, a) >= 0);
                  else pass_cnt++;
               end
            end
            2: for (int i = 0; i < 8; i++) begin
               rpi_ev(i == 0, 1'b1, sel, 1'b0);
               for (int d = 0; d < 2; d++) begin
                  chk_cnt++;
                  if (obs_din[d] !== mOut[d][7])
                     $display("FAIL rand_out d%0d bit%0d: got %b want %b", d, i, obs_din[d], mOut[d][7]);
                  else pass_cnt++;
               end
            end
            default: begin
               for (int i = 0; i < 8; i++) rpi_ev(1'b0, 1'b0, sel, 1'($urandom_range(0, 1)));
               rpi_ev(1'b1, 1'b0, sel, 1'b0);
            end
         endcase
         chk_cnt++;
         if ({tattn2, rattn2, tattn4, rattn4} !== {m_tattn(0), m_rattn(0), m_tattn(1), m_rattn(1)})
            $display("FAIL rand_attn op%0d: got %b%b%b%b want %b%b%b%b", op, tattn2, rattn2, tattn4, rattn4,
                     m_tattn(0), m_rattn(0), m_tattn(1), m_rattn(1));
         else pass_cnt++;
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, chk_cnt);
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      ti_a = 16'h0000; ti_din = 8'h00;
      idle_bus();
      r_clk = 1'b0; r_le = 1'b0; r_rt = 1'b0; r_dout = 1'b0; r_sel = 2'd0;
      test_reset();
      test_window();
      test_ti_write();
      test_rpi_commit();
      test_simul();
      test_reset_mid();
      test_nch4();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
